// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counting interval timer with valid/ready expiry events
//
// Optional feature macro: TIMER_PRESCALE_EN (divide ce by PRESCALE before each decrement).
//
// Parameters:
//   WIDTH      counter and preset width in bits
//   PRESCALE   ce cycles per decrement when TIMER_PRESCALE_EN is defined (>=1)
//
// Ports:
//   clk        in   1      clock, all logic on rising edge
//   rst        in   1      synchronous reset, active-high
//   load       in   1      strobe: capture load_val into the reload register
//   load_val   in   WIDTH  preset value
//   start      in   1      strobe: begin or resume counting
//   stop       in   1      strobe: pause counting (wins over start)
//   auto_rl    in   1      1 = reload and keep running on expiry, 0 = one-shot
//   ce         in   1      count enable / tick qualifier
//   count      out  WIDTH  current count value
//   busy       out  1      high while in RUN
//   evt_valid  out  1      expiry event pending
//   evt_ready  in   1      consumer accepts the event
//   overrun    out  1      sticky: expiry while previous event still pending

module countdown_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_rl,
    input  logic             ce,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             evt_valid_q, evt_valid_d;
    logic             overrun_q, overrun_d;
    // Marks the first cycle in RUN so a zero count expires once on entry.
    logic             enter_q, enter_d;
    logic             tick;
    logic             expire;
    logic             start_acc;

    if (PRESCALE < 1) begin : g_prescale_range
        $error("countdown_timer: PRESCALE must be >= 1");
    end

    // A start only takes effect outside RUN and when stop is not also asserted.
    assign start_acc = (state_q != S_RUN) && start && !stop;

`ifdef TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;

    assign tick = ce && (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q;
        if (load || start_acc) begin
            presc_d = '0;
        end else if ((state_q == S_RUN) && ce && !stop) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick = ce;
`endif

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = load ? load_val : reload_q;
        evt_valid_d = evt_valid_q;
        overrun_d   = overrun_q;
        expire      = 1'b0;

        case (state_q)
            S_IDLE, S_PAUSE: begin
                if (load) begin
                    count_d = load_val;
                end
                if (start && !stop) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (load) begin
                    count_d = load_val;
                end
                if (start && !stop) begin
                    state_d = S_RUN;
                    count_d = load ? load_val : reload_q;
                end
            end
            S_RUN: begin
                // A stop freezes the count; no decrement or expiry that cycle.
                if (stop) begin
                    state_d = S_PAUSE;
                end else if ((tick && (count_q <= WIDTH'(1))) ||
                             (enter_q && (count_q == '0))) begin
                    // count==0 with a tick only happens when auto-reloading zero;
                    // it expires instead of wrapping.
                    expire = 1'b1;
                    if (auto_rl) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        state_d = S_DONE;
                    end
                end else if (tick) begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end
        if (expire) begin
            evt_valid_d = 1'b1;
            if (evt_valid_q && !evt_ready) begin
                overrun_d = 1'b1;
            end
        end

        enter_d = (state_q != S_RUN) && (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            evt_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            enter_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            evt_valid_q <= evt_valid_d;
            overrun_q   <= overrun_d;
            enter_q     <= enter_d;
        end
    end

    assign count     = count_q;
    assign busy      = (state_q == S_RUN);
    assign evt_valid = evt_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed table-driven bench for countdown_timer

module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       auto_rl = 1'b0;
    logic       ce = 1'b0;
    logic [7:0] count;
    logic       busy;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic       overrun;

    int checks = 0;
    int passed = 0;

    countdown_timer #(.WIDTH(8), .PRESCALE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .stop      (stop),
        .auto_rl   (auto_rl),
        .ce        (ce),
        .count     (count),
        .busy      (busy),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         r, l;
        logic [7:0] lv;
        bit         st, sp, ar, c, er;
        logic [7:0] ec;
        bit         eb, ev, eo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, bit r, bit l, logic [7:0] lv, bit st, bit sp,
                                bit ar, bit c, bit er, logic [7:0] ec, bit eb, bit ev, bit eo);
        vec_t v;
        v.name = n; v.r = r; v.l = l; v.lv = lv; v.st = st; v.sp = sp;
        v.ar = ar; v.c = c; v.er = er; v.ec = ec; v.eb = eb; v.ev = ev; v.eo = eo;
        return v;
    endfunction

    task automatic cmp(string n, string f, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s.%s: got %0d expected %0d", n, f, act, exp);
    endtask

    // Drive one cycle of inputs, clock once, then sample just after the edge.
    task automatic step(vec_t v);
        rst = v.r; load = v.l; load_val = v.lv; start = v.st; stop = v.sp;
        auto_rl = v.ar; ce = v.c; evt_ready = v.er;
        @(posedge clk);
        #1;
        cmp(v.name, "count", int'(count), int'(v.ec));
        cmp(v.name, "busy", int'(busy), int'(v.eb));
        cmp(v.name, "evt_valid", int'(evt_valid), int'(v.ev));
        cmp(v.name, "overrun", int'(overrun), int'(v.eo));
    endtask

    initial begin
`ifndef TIMER_PRESCALE_EN
        //                name         r  l  lv  st sp ar c  er  count b  v  o
        vecs.push_back(mk("rst0",      1, 0, 0,  0, 0, 0, 0, 0,  0,    0, 0, 0));
        vecs.push_back(mk("rst1",      1, 0, 0,  0, 0, 0, 0, 0,  0,    0, 0, 0));
        vecs.push_back(mk("os_ld3",    0, 1, 3,  1, 0, 0, 1, 0,  3,    1, 0, 0));
        vecs.push_back(mk("os_2",      0, 0, 0,  0, 0, 0, 1, 0,  2,    1, 0, 0));
        vecs.push_back(mk("os_1",      0, 0, 0,  0, 0, 0, 1, 0,  1,    1, 0, 0));
        vecs.push_back(mk("os_done",   0, 0, 0,  0, 0, 0, 1, 0,  0,    0, 1, 0));
        vecs.push_back(mk("os_ack",    0, 0, 0,  0, 0, 0, 1, 1,  0,    0, 0, 0));
        vecs.push_back(mk("ar_ld2",    0, 1, 2,  1, 0, 1, 1, 0,  2,    1, 0, 0));
        vecs.push_back(mk("ar_1",      0, 0, 0,  0, 0, 1, 1, 0,  1,    1, 0, 0));
        vecs.push_back(mk("ar_exp1",   0, 0, 0,  0, 0, 1, 1, 0,  2,    1, 1, 0));
        vecs.push_back(mk("ar_1b",     0, 0, 0,  0, 0, 1, 1, 0,  1,    1, 1, 0));
        vecs.push_back(mk("ar_exp2",   0, 0, 0,  0, 0, 1, 1, 0,  2,    1, 1, 1));
        vecs.push_back(mk("ar_ack",    0, 0, 0,  0, 0, 1, 1, 1,  1,    1, 0, 1));
        vecs.push_back(mk("ar_stop",   0, 0, 0,  0, 1, 1, 1, 0,  1,    0, 0, 1));
        vecs.push_back(mk("p_ld5",     0, 1, 5,  0, 0, 0, 0, 0,  5,    0, 0, 1));
        vecs.push_back(mk("p_start",   0, 0, 0,  1, 0, 0, 1, 0,  5,    1, 0, 1));
        vecs.push_back(mk("p_4",       0, 0, 0,  0, 0, 0, 1, 0,  4,    1, 0, 1));
        vecs.push_back(mk("p_3",       0, 0, 0,  0, 0, 0, 1, 0,  3,    1, 0, 1));
        vecs.push_back(mk("p_stop",    0, 0, 0,  0, 1, 0, 1, 0,  3,    0, 0, 1));
        vecs.push_back(mk("p_hold",    0, 0, 0,  0, 0, 0, 1, 0,  3,    0, 0, 1));
        vecs.push_back(mk("p_stwin",   0, 0, 0,  1, 1, 0, 1, 0,  3,    0, 0, 1));
        vecs.push_back(mk("p_resume",  0, 0, 0,  1, 0, 0, 1, 0,  3,    1, 0, 1));
        vecs.push_back(mk("p_2",       0, 0, 0,  0, 0, 0, 1, 0,  2,    1, 0, 1));
        vecs.push_back(mk("p_1",       0, 0, 0,  0, 0, 0, 1, 0,  1,    1, 0, 1));
        vecs.push_back(mk("p_done",    0, 0, 0,  0, 0, 0, 1, 0,  0,    0, 1, 1));
        vecs.push_back(mk("p_ack",     0, 0, 0,  0, 0, 0, 0, 1,  0,    0, 0, 1));
        vecs.push_back(mk("rl_ld5",    0, 1, 5,  1, 0, 1, 1, 0,  5,    1, 0, 1));
        vecs.push_back(mk("rl_4",      0, 0, 0,  0, 0, 1, 1, 0,  4,    1, 0, 1));
        vecs.push_back(mk("rl_3",      0, 0, 0,  0, 0, 1, 1, 0,  3,    1, 0, 1));
        vecs.push_back(mk("rl_2",      0, 0, 0,  0, 0, 1, 1, 0,  2,    1, 0, 1));
        vecs.push_back(mk("rl_ld4run", 0, 1, 4,  0, 0, 1, 1, 0,  1,    1, 0, 1));
        vecs.push_back(mk("rl_new4",   0, 0, 0,  0, 0, 1, 1, 0,  4,    1, 1, 1));
        vecs.push_back(mk("rl_3ack",   0, 0, 0,  0, 0, 1, 1, 1,  3,    1, 0, 1));
        vecs.push_back(mk("rl_rst",    1, 0, 0,  0, 0, 1, 1, 0,  0,    0, 0, 0));
        vecs.push_back(mk("idle_ce",   0, 0, 0,  0, 0, 0, 1, 0,  0,    0, 0, 0));

        foreach (vecs[i]) step(vecs[i]);

        // Mid-run reset drops a pending event.
        step(mk("mr_ld9",   0, 1, 9, 1, 0, 1, 1, 0, 9, 1, 0, 0));
        step(mk("mr_8",     0, 0, 0, 0, 0, 1, 1, 0, 8, 1, 0, 0));
        step(mk("mr_rst",   1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));

        // Start with count 0 from IDLE: expiry on the first RUN cycle, no ce needed.
        step(mk("z_start",  0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        step(mk("z_exp",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(mk("z_ack",    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        // Auto-reload of 0 from DONE: expires every tick, never wraps to 255.
        step(mk("z_ar_st",  0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0));
        step(mk("z_ar_e1",  0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0));
        step(mk("z_ar_e2",  0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1));
        step(mk("z_ar_noce",0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1));
        step(mk("z_ar_hs",  0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 1));
`else
        step(mk("ps_rst",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk("ps_ld2",   0, 1, 2, 1, 0, 0, 1, 0, 2, 1, 0, 0));
        for (int k = 1; k <= 8; k++) begin
            logic [7:0] ec;
            ec = (k < 4) ? 8'd2 : (k < 8) ? 8'd1 : 8'd0;
            step(mk($sformatf("ps_ce%0d", k), 0, 0, 0, 0, 0, 0, 1, 0, ec,
                    (k < 8), (k == 8), 0));
        end
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
